// File: rtl/lane_fsm_pkg.sv
// lane_fsm_pkg: lane state codes shared with the lane FSM, successor function and monitor states.
package lane_fsm_pkg;
  localparam int IO_SIZE_G = 3;
  typedef enum logic [IO_SIZE_G-1:0] {
    IDLE  = 3'd0,
    S1_A  = 3'd1,
    S1_B  = 3'd2,
    S1_C  = 3'd3,
    S2_A  = 3'd4,
    S2_B  = 3'd5,
    S2_C  = 3'd6,
    ERROR = 3'd7
  } lane_state_t;
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, CORRECT} mon_state_t;
  function automatic lane_state_t next_state(input lane_state_t s);
    case (s)
      IDLE:    return S1_A;
      S1_A:    return S1_B;
      S1_B:    return S1_C;
      S1_C:    return S2_A;
      S2_A:    return S2_B;
      S2_B:    return S2_C;
      S2_C:    return IDLE;
      ERROR:   return IDLE;
      default: return ERROR;
    endcase
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_WIDTH_G = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   inc_i,
  input  logic                   clr_i,
  output logic [CNT_WIDTH_G-1:0] cnt_o
);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_o <= '0;
    else if (clr_i) cnt_o <= '0;
    else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/lane_fsm_monitor.sv
// lane_fsm_monitor: tracks a lane state code stream, flags illegal successors,
// requests correction from the lane FSM and keeps saturating statistics.
module lane_fsm_monitor
  import lane_fsm_pkg::*;
#(
  parameter int CNT_WIDTH_G      = 16,
  parameter int CORRECT_CYCLES_G = 4,
  parameter int RESYNC_MATCHES_G = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   valid_i,
  input  logic [IO_SIZE_G-1:0]   data_i,
  input  logic                   clear_cnt_i,
  output logic                   correct_o,
  output logic                   locked_o,
  output logic                   mismatch_o,
  output logic [CNT_WIDTH_G-1:0] mismatch_cnt_o,
  output logic [CNT_WIDTH_G-1:0] error_cnt_o,
  output logic [CNT_WIDTH_G-1:0] loop_cnt_o
);
  localparam int RW = $clog2(RESYNC_MATCHES_G + 1);
  localparam int TW = $clog2(CORRECT_CYCLES_G + 1);
  mon_state_t  state_q, state_d;
  lane_state_t prev_q, prev_d, data;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] timer_q, timer_d;
  logic correct_d, locked_d, mismatch_d, hit, mis_inc, loop_inc, err_inc;
  always_comb begin
    data       = lane_state_t'(data_i);
    hit        = data == next_state(prev_q);
    state_d    = state_q;
    prev_d     = valid_i ? data : prev_q;
    run_d      = run_q;
    timer_d    = timer_q;
    correct_d  = correct_o;
    locked_d   = locked_o;
    mismatch_d = 1'b0;
    mis_inc    = 1'b0;
    loop_inc   = 1'b0;
    err_inc    = valid_i && data == ERROR;
    case (state_q)
      UNLOCKED: if (valid_i) begin
        run_d   = '0;
        state_d = ACQUIRE;
      end
      ACQUIRE: if (valid_i) begin
        run_d = hit ? run_q + 1'b1 : '0;
        if (hit && run_q + 1'b1 == RW'(RESYNC_MATCHES_G)) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
        end
      end
      LOCKED: if (valid_i) begin
        if (!hit) begin
          mismatch_d = 1'b1;
          mis_inc    = 1'b1;
          locked_d   = 1'b0;
          correct_d  = 1'b1;
          timer_d    = TW'(CORRECT_CYCLES_G);
          state_d    = CORRECT;
        end else loop_inc = prev_q == S2_C;
      end
      CORRECT: begin
        // timer is loaded with the hold length, so the request drops as it leaves 1
        if (timer_q <= TW'(1)) begin
          correct_d = 1'b0;
          run_d     = '0;
          state_d   = ACQUIRE;
        end else timer_d = timer_q - 1'b1;
      end
      default: state_d = UNLOCKED;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q    <= UNLOCKED;
      prev_q     <= IDLE;
      run_q      <= '0;
      timer_q    <= '0;
      correct_o  <= 1'b0;
      locked_o   <= 1'b0;
      mismatch_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      timer_q    <= timer_d;
      correct_o  <= correct_d;
      locked_o   <= locked_d;
      mismatch_o <= mismatch_d;
    end
  sat_counter #(.CNT_WIDTH_G(CNT_WIDTH_G)) u_mis_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(mis_inc), .clr_i(clear_cnt_i), .cnt_o(mismatch_cnt_o)
  );
  sat_counter #(.CNT_WIDTH_G(CNT_WIDTH_G)) u_err_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(err_inc), .clr_i(clear_cnt_i), .cnt_o(error_cnt_o)
  );
  sat_counter #(.CNT_WIDTH_G(CNT_WIDTH_G)) u_loop_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(loop_inc), .clr_i(clear_cnt_i), .cnt_o(loop_cnt_o)
  );
endmodule

// File: tb/tb_lane_fsm_monitor.sv
// tb_lane_fsm_monitor: directed scenarios against hand-computed expectations;
// a second narrow-counter instance exposes saturation.
module tb_lane_fsm_monitor;
  import lane_fsm_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, clr = 1'b0;
  logic [2:0] data = 3'd0;
  logic correct, locked, mismatch;
  logic [15:0] mis_cnt, err_cnt, loop_cnt;
  logic s_correct, s_locked, s_mismatch;
  logic [1:0] s_mis_cnt, s_err_cnt, s_loop_cnt;
  int checks = 0, errors = 0;

  lane_fsm_monitor dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .data_i(data), .clear_cnt_i(clr),
    .correct_o(correct), .locked_o(locked), .mismatch_o(mismatch),
    .mismatch_cnt_o(mis_cnt), .error_cnt_o(err_cnt), .loop_cnt_o(loop_cnt)
  );
  lane_fsm_monitor #(.CNT_WIDTH_G(2)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .data_i(data), .clear_cnt_i(clr),
    .correct_o(s_correct), .locked_o(s_locked), .mismatch_o(s_mismatch),
    .mismatch_cnt_o(s_mis_cnt), .error_cnt_o(s_err_cnt), .loop_cnt_o(s_loop_cnt)
  );

  always #5 clk = ~clk;

  task automatic send(input logic v, input logic [2:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({correct, locked, mismatch} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {correct, locked, mismatch}); end
    checks++; if (mis_cnt !== 16'd0) begin errors++; $display("FAIL reset_mis_cnt got %0d exp 0", mis_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (loop_cnt !== 16'd0) begin errors++; $display("FAIL reset_loop_cnt got %0d exp 0", loop_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock_loops;
    send(1'b1, IDLE);
    send(1'b1, S1_A);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b exp 0", locked); end
    send(1'b1, S1_B);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_after_s1b got %b exp 1", locked); end
    for (int i = 3; i <= 7; i++) send(1'b1, 3'(i % 7));
    repeat (2) for (int i = 1; i <= 7; i++) send(1'b1, 3'(i % 7));
    checks++; if (loop_cnt !== 16'd3) begin errors++; $display("FAIL loops_cnt got %0d exp 3", loop_cnt); end
    checks++; if (mis_cnt !== 16'd0) begin errors++; $display("FAIL loops_mis_cnt got %0d exp 0", mis_cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loops_locked got %b exp 1", locked); end
  endtask

  task automatic test_mismatch;
    send(1'b1, S1_A);
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_legal_pulse got %b exp 0", mismatch); end
    send(1'b1, S2_A);
    checks++; if ({mismatch, correct, locked} !== 3'b110) begin errors++; $display("FAIL mm_detect got %b exp 110", {mismatch, correct, locked}); end
    checks++; if (mis_cnt !== 16'd1) begin errors++; $display("FAIL mm_cnt got %0d exp 1", mis_cnt); end
    send(1'b0, S2_A);
    checks++; if ({mismatch, correct} !== 2'b01) begin errors++; $display("FAIL mm_pulse_end got %b exp 01", {mismatch, correct}); end
    send(1'b0, S2_A);
    send(1'b0, S2_A);
    checks++; if (correct !== 1'b1) begin errors++; $display("FAIL mm_correct_4th got %b exp 1", correct); end
    send(1'b0, S2_A);
    checks++; if ({correct, locked} !== 2'b00) begin errors++; $display("FAIL mm_correct_end got %b exp 00", {correct, locked}); end
  endtask

  task automatic test_recovery;
    send(1'b1, S2_B);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rec_early got %b exp 0", locked); end
    send(1'b1, S2_C);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rec_locked got %b exp 1", locked); end
    send(1'b1, IDLE);
    checks++; if (loop_cnt !== 16'd4) begin errors++; $display("FAIL rec_loop_cnt got %0d exp 4", loop_cnt); end
    checks++; if (mis_cnt !== 16'd1) begin errors++; $display("FAIL rec_mis_cnt got %0d exp 1", mis_cnt); end
  endtask

  task automatic test_valid_gaps;
    int bad = 0;
    for (int i = 1; i <= 7; i++) begin
      send(1'b1, 3'(i % 7));
      if (mismatch !== 1'b0 || locked !== 1'b1) bad++;
      send(1'b0, ERROR);
      if (mismatch !== 1'b0 || locked !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL gaps_bad_cycles got %0d exp 0", bad); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL gaps_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (loop_cnt !== 16'd5) begin errors++; $display("FAIL gaps_loop_cnt got %0d exp 5", loop_cnt); end
  endtask

  task automatic test_error_clear;
    send(1'b1, ERROR);
    send(1'b1, ERROR);
    send(1'b1, ERROR);
    send(1'b0, IDLE);
    send(1'b0, IDLE);
    checks++; if (err_cnt !== 16'd3) begin errors++; $display("FAIL err_cnt got %0d exp 3", err_cnt); end
    checks++; if (mis_cnt !== 16'd2) begin errors++; $display("FAIL err_mis_cnt got %0d exp 2", mis_cnt); end
    checks++; if (correct !== 1'b0) begin errors++; $display("FAIL err_correct_end got %b exp 0", correct); end
    send(1'b1, IDLE);
    send(1'b1, S1_A);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_relock got %b exp 1", locked); end
    clr = 1'b1;
    send(1'b1, S2_A);
    clr = 1'b0;
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL clr_mm_pulse got %b exp 1", mismatch); end
    checks++; if ({mis_cnt, err_cnt, loop_cnt} !== 48'd0) begin errors++; $display("FAIL clr_counters got %0d/%0d/%0d exp 0/0/0", mis_cnt, err_cnt, loop_cnt); end
    repeat (4) send(1'b0, S2_A);
  endtask

  task automatic test_saturation;
    repeat (5) send(1'b1, ERROR);
    checks++; if (err_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide_err got %0d exp 5", err_cnt); end
    checks++; if (s_err_cnt !== 2'd3) begin errors++; $display("FAIL sat_narrow_err got %0d exp 3", s_err_cnt); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL sat_no_mm got %b exp 0", mismatch); end
    clr = 1'b1;
    send(1'b0, IDLE);
    clr = 1'b0;
    checks++; if ({err_cnt, s_err_cnt} !== 18'd0) begin errors++; $display("FAIL sat_clear got %0d/%0d exp 0/0", err_cnt, s_err_cnt); end
  endtask

  task automatic test_reset_mid_correct;
    send(1'b1, IDLE);
    send(1'b1, S1_A);
    send(1'b1, S1_A);
    send(1'b0, IDLE);
    checks++; if (correct !== 1'b1) begin errors++; $display("FAIL rmc_correct_before got %b exp 1", correct); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({correct, locked, mismatch} !== 3'b000) begin errors++; $display("FAIL rmc_async_flags got %b exp 000", {correct, locked, mismatch}); end
    checks++; if (mis_cnt !== 16'd0) begin errors++; $display("FAIL rmc_async_cnt got %0d exp 0", mis_cnt); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, IDLE);
    send(1'b1, S1_A);
    send(1'b1, S1_B);
    checks++; if ({locked, correct} !== 2'b10) begin errors++; $display("FAIL rmc_relock got %b exp 10", {locked, correct}); end
  endtask

  initial begin
    test_reset;
    test_lock_loops;
    test_mismatch;
    test_recovery;
    test_valid_gaps;
    test_error_clear;
    test_saturation;
    test_reset_mid_correct;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
